// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_pkg
// Description : Shared definitions for the FC layer sequencer: one-hot operand
//               type codes, sequencer state encoding and a type-check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    // One-hot operand type codes presented by the read controller
    localparam logic [2:0] FC_DT_DATA   = 3'b001;
    localparam logic [2:0] FC_DT_WEIGHT = 3'b010;
    localparam logic [2:0] FC_DT_BIAS   = 3'b100;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        FC_ST_IDLE   = 3'd0,
        FC_ST_LSTART = 3'd1,
        FC_ST_RD     = 3'd2,
        FC_ST_WR     = 3'd3,
        FC_ST_NEXT   = 3'd4,
        FC_ST_FIN    = 3'd5
    } fc_seq_state_t;

    // True only for one of the three legal operand codes
    function automatic logic fc_dt_onehot(input logic [2:0] dt);
        return (dt == FC_DT_DATA) || (dt == FC_DT_WEIGHT) || (dt == FC_DT_BIAS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fc_addr_gen
// Description : Combinational base-address generator. Read data ping-pongs
//               between two buffers by layer parity, writes target the other
//               buffer, weight/bias bases advance by a fixed stride per layer.
//               All arithmetic wraps in ADDR_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_addr_gen
    import fc_pkg::*;
#(
    parameter int          ADDR_W        = 28,
    parameter int          LAYER_W       = 4,
    parameter int unsigned DATA_BASE_A   = 32'h0,
    parameter int unsigned DATA_BASE_B   = 32'h100000,
    parameter int unsigned WEIGHT_BASE   = 32'h200000,
    parameter int unsigned WEIGHT_STRIDE = 32'h10000,
    parameter int unsigned BIAS_BASE     = 32'h800000,
    parameter int unsigned BIAS_STRIDE   = 32'h100
) (
    input  logic [LAYER_W-1:0] i_layer,
    input  logic [2:0]         i_data_type,
    input  logic               i_is_wr,
    output logic [ADDR_W-1:0]  o_addr
);

    localparam logic [ADDR_W-1:0] C_DATA_A   = ADDR_W'(DATA_BASE_A);
    localparam logic [ADDR_W-1:0] C_DATA_B   = ADDR_W'(DATA_BASE_B);
    localparam logic [ADDR_W-1:0] C_W_BASE   = ADDR_W'(WEIGHT_BASE);
    localparam logic [ADDR_W-1:0] C_W_STRIDE = ADDR_W'(WEIGHT_STRIDE);
    localparam logic [ADDR_W-1:0] C_B_BASE   = ADDR_W'(BIAS_BASE);
    localparam logic [ADDR_W-1:0] C_B_STRIDE = ADDR_W'(BIAS_STRIDE);

    logic [ADDR_W-1:0] w_layer_ext;

    // Select the operand base for the current layer; illegal types yield 0
    always_comb begin
        w_layer_ext = ADDR_W'(i_layer);
        o_addr      = '0;
        if (i_is_wr) begin
            o_addr = i_layer[0] ? C_DATA_A : C_DATA_B;
        end else begin
            case (i_data_type)
                FC_DT_DATA:   o_addr = i_layer[0] ? C_DATA_B : C_DATA_A;
                FC_DT_WEIGHT: o_addr = C_W_BASE + w_layer_ext * C_W_STRIDE;
                FC_DT_BIAS:   o_addr = C_B_BASE + w_layer_ext * C_B_STRIDE;
                default:      o_addr = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fc_seq_ctrl
// Description : Multi-layer FC sequencer. Runs num_layers layers back to back,
//               answering read-controller base-address requests and issuing
//               the write base for each layer's output.
//               Optional feature macro: FC_SEQ_CTRL_TIMEOUT_EN enables a
//               watchdog on the RD/WR waits that raises fc_err and finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_seq_ctrl
    import fc_pkg::*;
#(
    parameter int          ADDR_W        = 28,
    parameter int          LAYER_W       = 4,
    parameter int unsigned DATA_BASE_A   = 32'h0,
    parameter int unsigned DATA_BASE_B   = 32'h100000,
    parameter int unsigned WEIGHT_BASE   = 32'h200000,
    parameter int unsigned WEIGHT_STRIDE = 32'h10000,
    parameter int unsigned BIAS_BASE     = 32'h800000,
    parameter int unsigned BIAS_STRIDE   = 32'h100,
    parameter int unsigned TIMEOUT_CYC   = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fc_en,
    input  logic [LAYER_W-1:0] num_layers,
    output logic               fc_busy,
    output logic               fc_done,
    output logic               fc_err,
    output logic [LAYER_W-1:0] fc_layer,
    output logic               rd_layer_start,
    input  logic               rd_addr_rq,
    input  logic [2:0]         rd_data_type,
    input  logic               rd_end,
    output logic               rd_addr_en,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               wr_addr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    input  logic               wr_done
);

    localparam logic [2:0] C_ST_IDLE   = FC_ST_IDLE;
    localparam logic [2:0] C_ST_LSTART = FC_ST_LSTART;
    localparam logic [2:0] C_ST_RD     = FC_ST_RD;
    localparam logic [2:0] C_ST_WR     = FC_ST_WR;
    localparam logic [2:0] C_ST_NEXT   = FC_ST_NEXT;
    localparam logic [2:0] C_ST_FIN    = FC_ST_FIN;

    logic [2:0]         r_state_q,   w_state_d;
    logic [LAYER_W-1:0] r_num_q,     w_num_d;
    logic [LAYER_W-1:0] r_layer_q,   w_layer_d;
    logic               r_busy_q,    w_busy_d;
    logic               r_done_q,    w_done_d;
    logic               r_err_q,     w_err_d;
    logic               r_lstart_q,  w_lstart_d;
    logic               r_rd_en_q,   w_rd_en_d;
    logic [ADDR_W-1:0]  r_rd_addr_q, w_rd_addr_d;
    logic               r_wr_en_q,   w_wr_en_d;
    logic [ADDR_W-1:0]  r_wr_addr_q, w_wr_addr_d;

    logic [ADDR_W-1:0]  w_gen_addr;
    logic [LAYER_W-1:0] w_layer_inc;
    logic               w_rq_ok;
    logic               w_timeout;

    assign w_layer_inc = r_layer_q + LAYER_W'(1);
    assign w_rq_ok     = rd_addr_rq && fc_dt_onehot(rd_data_type);

    // rd_end selects the write-base path, so a coincident request gets nothing
    fc_addr_gen #(
        .ADDR_W        (ADDR_W),
        .LAYER_W       (LAYER_W),
        .DATA_BASE_A   (DATA_BASE_A),
        .DATA_BASE_B   (DATA_BASE_B),
        .WEIGHT_BASE   (WEIGHT_BASE),
        .WEIGHT_STRIDE (WEIGHT_STRIDE),
        .BIAS_BASE     (BIAS_BASE),
        .BIAS_STRIDE   (BIAS_STRIDE)
    ) u_addr_gen (
        .i_layer     (r_layer_q),
        .i_data_type (rd_data_type),
        .i_is_wr     (rd_end),
        .o_addr      (w_gen_addr)
    );

`ifdef FC_SEQ_CTRL_TIMEOUT_EN
    localparam int C_WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT_CYC - 1);

    logic [C_WD_W-1:0] r_wd_q, w_wd_d;
    logic              w_wd_wait;
    logic              w_wd_kick;

    // Watchdog: counts stalled RD/WR cycles; any accepted event or state change restarts it
    always_comb begin
        w_wd_wait = (r_state_q == C_ST_RD) || (r_state_q == C_ST_WR);
        w_wd_kick = (r_state_q == C_ST_RD) ? (rd_end || w_rq_ok) : wr_done;
        w_timeout = w_wd_wait && !w_wd_kick && (r_wd_q == C_WD_LAST);
        w_wd_d    = (w_wd_wait && !w_wd_kick && !w_timeout) ? r_wd_q + C_WD_W'(1) : '0;
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_q <= '0;
        end else begin
            r_wd_q <= w_wd_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Sequencer next-state and registered-output logic
    always_comb begin
        w_state_d   = r_state_q;
        w_num_d     = r_num_q;
        w_layer_d   = r_layer_q;
        w_err_d     = r_err_q;
        w_done_d    = 1'b0;
        w_lstart_d  = 1'b0;
        w_rd_en_d   = 1'b0;
        w_rd_addr_d = r_rd_addr_q;
        w_wr_en_d   = 1'b0;
        w_wr_addr_d = r_wr_addr_q;
        w_busy_d    = (r_state_q != C_ST_IDLE) && (r_state_q != C_ST_FIN);
        case (r_state_q)
            C_ST_IDLE: begin
                if (fc_en) begin
                    w_num_d   = num_layers;
                    w_layer_d = '0;
                    w_err_d   = 1'b0;
                    w_state_d = (num_layers == '0) ? C_ST_FIN : C_ST_LSTART;
                end
            end
            C_ST_LSTART: begin
                // Layer 0's pulse trails the start handshake by one cycle;
                // later layers pulse on the NEXT->LSTART edge instead.
                w_lstart_d = (r_layer_q == '0);
                w_state_d  = C_ST_RD;
            end
            C_ST_RD: begin
                if (rd_end) begin
                    w_wr_addr_d = w_gen_addr;
                    w_wr_en_d   = 1'b1;
                    w_state_d   = C_ST_WR;
                end else if (w_rq_ok) begin
                    w_rd_addr_d = w_gen_addr;
                    w_rd_en_d   = 1'b1;
                end else if (w_timeout) begin
                    w_err_d   = 1'b1;
                    w_state_d = C_ST_FIN;
                end
            end
            C_ST_WR: begin
                if (wr_done) begin
                    w_state_d = C_ST_NEXT;
                end else if (w_timeout) begin
                    w_err_d   = 1'b1;
                    w_state_d = C_ST_FIN;
                end
            end
            C_ST_NEXT: begin
                if (w_layer_inc == r_num_q) begin
                    w_state_d = C_ST_FIN;
                end else begin
                    w_layer_d  = w_layer_inc;
                    w_lstart_d = 1'b1;
                    w_state_d  = C_ST_LSTART;
                end
            end
            C_ST_FIN: begin
                w_done_d  = 1'b1;
                w_state_d = C_ST_IDLE;
            end
            default: begin
                w_state_d = C_ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any run without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= C_ST_IDLE;
            r_num_q     <= '0;
            r_layer_q   <= '0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_err_q     <= 1'b0;
            r_lstart_q  <= 1'b0;
            r_rd_en_q   <= 1'b0;
            r_rd_addr_q <= '0;
            r_wr_en_q   <= 1'b0;
            r_wr_addr_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_num_q     <= w_num_d;
            r_layer_q   <= w_layer_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_err_q     <= w_err_d;
            r_lstart_q  <= w_lstart_d;
            r_rd_en_q   <= w_rd_en_d;
            r_rd_addr_q <= w_rd_addr_d;
            r_wr_en_q   <= w_wr_en_d;
            r_wr_addr_q <= w_wr_addr_d;
        end
    end

    assign fc_busy        = r_busy_q;
    assign fc_done        = r_done_q;
    assign fc_err         = r_err_q;
    assign fc_layer       = r_layer_q;
    assign rd_layer_start = r_lstart_q;
    assign rd_addr_en     = r_rd_en_q;
    assign rd_addr        = r_rd_addr_q;
    assign wr_addr_en     = r_wr_en_q;
    assign wr_addr        = r_wr_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_seq_ctrl
// Description : Scoreboard bench for fc_seq_ctrl. Stimulus pushes expected
//               pulses into a queue; a negedge monitor pops and compares.
//               Timeout scenario compiled in with FC_SEQ_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_seq_ctrl;
    import fc_pkg::*;

`ifdef FC_SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned C_TO_CYC = 16;
`else
    localparam int unsigned C_TO_CYC = 4096;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fc_en = 1'b0;
    logic [3:0]  num_layers = '0;
    logic        fc_busy, fc_done, fc_err, rd_layer_start;
    logic [3:0]  fc_layer;
    logic        rd_addr_rq = 1'b0;
    logic [2:0]  rd_data_type = '0;
    logic        rd_end = 1'b0;
    logic        rd_addr_en, wr_addr_en;
    logic [27:0] rd_addr, wr_addr;
    logic        wr_done = 1'b0;

    always #5 clk = ~clk;

    fc_seq_ctrl #(
        .ADDR_W        (28),
        .LAYER_W       (4),
        .DATA_BASE_A   (32'h0),
        .DATA_BASE_B   (32'h100000),
        .WEIGHT_BASE   (32'h200000),
        .WEIGHT_STRIDE (32'h10000),
        .BIAS_BASE     (32'h800000),
        .BIAS_STRIDE   (32'h100),
        .TIMEOUT_CYC   (C_TO_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fc_en          (fc_en),
        .num_layers     (num_layers),
        .fc_busy        (fc_busy),
        .fc_done        (fc_done),
        .fc_err         (fc_err),
        .fc_layer       (fc_layer),
        .rd_layer_start (rd_layer_start),
        .rd_addr_rq     (rd_addr_rq),
        .rd_data_type   (rd_data_type),
        .rd_end         (rd_end),
        .rd_addr_en     (rd_addr_en),
        .rd_addr        (rd_addr),
        .wr_addr_en     (wr_addr_en),
        .wr_addr        (wr_addr),
        .wr_done        (wr_done)
    );

    localparam int EV_LS   = 0;
    localparam int EV_RD   = 1;
    localparam int EV_WR   = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int          kind;
        logic [27:0] val;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Hand-computed expected bases for a three-layer run
    logic [27:0] exp_rd [3][3] = '{
        '{28'h0,      28'h200000, 28'h800000},
        '{28'h100000, 28'h210000, 28'h800100},
        '{28'h0,      28'h220000, 28'h800200}
    };
    logic [27:0] exp_wr [3] = '{28'h100000, 28'h0, 28'h100000};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [27:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_pop(input int kind, input logic [27:0] val, input string name);
        ev_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected pulse with value 'h%0h, nothing queued", name, val);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_fail++;
                $display("FAIL %s: got event %0d value 'h%0h, expected event %0d value 'h%0h",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_layer_start) expect_pop(EV_LS, 28'(fc_layer), "rd_layer_start");
            if (rd_addr_en)     expect_pop(EV_RD, rd_addr, "rd_addr");
            if (wr_addr_en)     expect_pop(EV_WR, wr_addr, "wr_addr");
            if (fc_done) begin
                expect_pop(EV_DONE, 28'h0, "fc_done");
                chk("busy_low_with_done", 64'(fc_busy), 64'h0);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int maxc, input string name);
        int c = 0;
        while (sb.size() != 0 && c < maxc) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk({"drain_", name}, 64'(sb.size()), 64'h0);
        sb.delete();
    endtask

    task automatic start(input logic [3:0] n);
        align();
        fc_en      = 1'b1;
        num_layers = n;
        align();
        fc_en      = 1'b0;
        num_layers = 4'hf;
    endtask

    task automatic three_reads(input logic [27:0] a0, input logic [27:0] a1, input logic [27:0] a2);
        push(EV_RD, a0);
        push(EV_RD, a1);
        push(EV_RD, a2);
        align();
        rd_addr_rq = 1'b1;
        rd_data_type = FC_DT_DATA;
        align();
        rd_data_type = FC_DT_WEIGHT;
        align();
        rd_data_type = FC_DT_BIAS;
        align();
        rd_addr_rq = 1'b0;
        rd_data_type = '0;
        wait_drain(6, "reads");
    endtask

    task automatic finish_reads(input logic [27:0] wa);
        push(EV_WR, wa);
        align();
        rd_end = 1'b1;
        align();
        rd_end = 1'b0;
        wait_drain(4, "wr_addr");
    endtask

    task automatic pulse_wr_done();
        align();
        wr_done = 1'b1;
        align();
        wr_done = 1'b0;
    endtask

    task automatic run_layer(input logic [3:0] l, input logic [27:0] a0, input logic [27:0] a1,
                             input logic [27:0] a2, input logic [27:0] wa, input logic last);
        push(EV_LS, 28'(l));
        wait_drain(8, "lstart");
        chk("busy_in_layer", 64'(fc_busy), 64'h1);
        three_reads(a0, a1, a2);
        finish_reads(wa);
        if (last) push(EV_DONE, 28'h0);
        pulse_wr_done();
        if (last) wait_drain(6, "done");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state
        #12;
        chk("reset_outputs",
            {fc_busy, fc_done, fc_err, fc_layer, rd_layer_start, rd_addr_en, rd_addr, wr_addr_en, wr_addr},
            64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-layer run with ping-pong data and strided weights/biases
        start(4'd3);
        for (int l = 0; l < 3; l++) begin
            run_layer(4'(l), exp_rd[l][0], exp_rd[l][1], exp_rd[l][2], exp_wr[l], l == 2);
        end
        chk("layer_held_after_done", 64'(fc_layer), 64'h2);
        chk("busy_after_done", 64'(fc_busy), 64'h0);

        // Zero layers: done two cycles after fc_en, no transactions
        push(EV_DONE, 28'h0);
        start(4'd0);
        chk("zero_busy", 64'(fc_busy), 64'h0);
        chk("zero_done_early", 64'(fc_done), 64'h0);
        align();
        chk("zero_done_latency", 64'(fc_done), 64'h1);
        chk("zero_layer", 64'(fc_layer), 64'h0);
        wait_drain(4, "zero_done");

        // Illegal type ignored; coincident request and rd_end gives write only
        start(4'd1);
        push(EV_LS, 28'h0);
        wait_drain(8, "lstart_edge");
        align();
        rd_addr_rq   = 1'b1;
        rd_data_type = 3'b011;
        align();
        rd_addr_rq   = 1'b0;
        rd_data_type = '0;
        align();
        chk("bad_type_no_pulse", 64'(rd_addr_en), 64'h0);
        push(EV_WR, 28'h100000);
        rd_addr_rq   = 1'b1;
        rd_data_type = FC_DT_WEIGHT;
        rd_end       = 1'b1;
        align();
        rd_addr_rq   = 1'b0;
        rd_data_type = '0;
        rd_end       = 1'b0;
        chk("coincident_no_rd", 64'(rd_addr_en), 64'h0);
        wait_drain(4, "coincident_wr");
        push(EV_DONE, 28'h0);
        pulse_wr_done();
        wait_drain(6, "edge_done");

        // Reset during WR of layer 1, then a clean restart at layer 0
        start(4'd2);
        run_layer(4'd0, exp_rd[0][0], exp_rd[0][1], exp_rd[0][2], exp_wr[0], 1'b0);
        push(EV_LS, 28'h1);
        wait_drain(8, "lstart_l1");
        three_reads(exp_rd[1][0], exp_rd[1][1], exp_rd[1][2]);
        finish_reads(exp_wr[1]);
        align();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs",
            {fc_busy, fc_done, fc_err, fc_layer, rd_layer_start, rd_addr_en, rd_addr, wr_addr_en, wr_addr},
            64'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start(4'd1);
        run_layer(4'd0, 28'h0, 28'h200000, 28'h800000, 28'h100000, 1'b1);

`ifdef FC_SEQ_CTRL_TIMEOUT_EN
        // Watchdog: wr_done withheld for 16 WR cycles
        start(4'd1);
        push(EV_LS, 28'h0);
        wait_drain(8, "to_lstart");
        push(EV_WR, 28'h100000);
        push(EV_DONE, 28'h0);
        align();
        rd_end = 1'b1;
        align();
        rd_end = 1'b0;
        repeat (15) align();
        chk("err_before_limit", 64'(fc_err), 64'h0);
        align();
        chk("err_at_limit", 64'(fc_err), 64'h1);
        wait_drain(4, "to_done");
        chk("err_sticky", 64'(fc_err), 64'h1);
        start(4'd1);
        chk("err_cleared_on_start", 64'(fc_err), 64'h0);
        run_layer(4'd0, 28'h0, 28'h200000, 28'h800000, 28'h100000, 1'b1);
`endif

        repeat (5) align();
        chk("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_seq_ctrl.md
# fc_seq_ctrl

Multi-layer sequencer for the fully-connected engine. It sits between the host-facing start/done pair and the FC read and write controllers. It runs a runtime-selected number of FC layers back to back and hands each controller the base address of every operand. Data buffers ping-pong between two regions, so layer k's output becomes layer k+1's input. Weight and bias addresses advance by a fixed stride per layer.

## Interface
Parameters:
- ADDR_W, 28, address width of every address port
- LAYER_W, 4, width of layer count and index
- DATA_BASE_A, 0, ping data buffer base
- DATA_BASE_B, 'h100000, pong data buffer base
- WEIGHT_BASE, 'h200000, layer-0 weight base
- WEIGHT_STRIDE, 'h10000, weight offset per layer
- BIAS_BASE, 'h800000, layer-0 bias base
- BIAS_STRIDE, 'h100, bias offset per layer
- TIMEOUT_CYC, 4096, watchdog limit (used only with FC_SEQ_CTRL_TIMEOUT_EN)

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- fc_en  in  1  start request, sampled in IDLE
- num_layers  in  LAYER_W  layer count, captured on accepted start
- fc_busy  out  1  high from the cycle after start until done
- fc_done  out  1  one-cycle completion pulse
- fc_err  out  1  sticky watchdog error, cleared on next accepted start
- fc_layer  out  LAYER_W  index of the current layer
- rd_layer_start  out  1  one-cycle pulse at the start of each layer's read phase
- rd_addr_rq  in  1  one-cycle base-address request from the read controller
- rd_data_type  in  3  one-hot operand type, valid with rd_addr_rq: 001 data, 010 weight, 100 bias
- rd_end  in  1  one-cycle pulse: all reads for the layer are finished
- rd_addr_en  out  1  one-cycle address-valid pulse
- rd_addr  out  ADDR_W  base address; held between pulses
- wr_addr_en  out  1  one-cycle write-base-valid pulse
- wr_addr  out  ADDR_W  write base address; held between pulses
- wr_done  in  1  one-cycle pulse: the layer's writeback is complete

## Operation
- States: IDLE, LSTART, RD, WR, NEXT, FIN.
- IDLE:
  - fc_en=1 captures num_layers, clears fc_layer and fc_err, and goes to LSTART.
  - If num_layers=0, it goes to FIN instead, with no transactions.
- LSTART: pulses rd_layer_start, then goes to RD.
- RD:
  - rd_end=1: register wr_addr and pulse wr_addr_en, then go to WR.
  - Otherwise, rd_addr_rq=1 with a one-hot type: register rd_addr and pulse rd_addr_en, then stay in RD.
  - A request with a non-one-hot type is ignored: no pulse is issued.
- Simultaneous rd_addr_rq and rd_end: rd_end wins and the request is dropped.
- WR: wr_done=1 goes to NEXT.
- NEXT:
  - fc_layer+1 == num_layers goes to FIN.
  - Otherwise, fc_layer increments and the block goes to LSTART.
- FIN: pulses fc_done and returns to IDLE.
- fc_en outside IDLE is ignored. num_layers changes after start have no effect.
- Address rules. All arithmetic is in ADDR_W bits; overflow wraps silently. L = fc_layer.
  - data read: DATA_BASE_A when L is even, DATA_BASE_B when L is odd.
  - write: the opposite buffer from the data read.
  - weight: WEIGHT_BASE + L*WEIGHT_STRIDE.
  - bias: BIAS_BASE + L*BIAS_STRIDE.
- Reset: all outputs are 0, state is IDLE, and the captured count and layer index are 0. Reset assertion mid-run aborts immediately; fc_done is not pulsed.

## Timing
- Start: fc_en sampled at edge 0 → fc_busy=1 and rd_layer_start=1 after edge 1. Read requests are accepted from edge 2 onward.
- Address response: rd_addr_rq sampled at edge n → rd_addr_en=1 with rd_addr valid after edge n (one-cycle latency). The block accepts back-to-back requests on consecutive cycles.
- rd_end to wr_addr_en latency: 1 cycle.
- wr_done to the next layer:
  - wr_done at edge n → NEXT after edge n.
  - rd_layer_start after edge n+1 for a further layer.
  - fc_done after edge n+2 when it was the last layer.
- fc_busy:
  - Falls in the same cycle fc_done is high.
  - fc_done and fc_busy are never high together.
  - fc_layer holds its final value until the next start.
- Minimum per-layer overhead outside the read controller: 4 cycles.

## Configuration
- FC_SEQ_CTRL_TIMEOUT_EN defined:
  - The watchdog counter counts cycles in RD or WR.
  - It resets on every accepted rd_addr_rq, rd_end or wr_done and on every state change.
  - Reaching TIMEOUT_CYC sets fc_err=1 and goes to FIN, which pulses fc_done.
- Undefined: the counter is absent, fc_err is tied to 0, and RD/WR wait indefinitely.

## Structure
- Shared package fc_pkg:
  - one-hot operand-type constants FC_DT_DATA, FC_DT_WEIGHT, FC_DT_BIAS
  - state enum fc_seq_state_t
- Sub-module fc_addr_gen (combinational):
  - inputs: layer index, operand type, read/write select
  - output: base address, computed from the parameters
- The FSM registers the output of fc_addr_gen.

## Test plan
- num_layers=3, reader requests data, weight, bias each layer → rd_addr sequence:
  - layer 0: 0, 'h200000, 'h800000
  - layer 1: 'h100000, 'h210000, 'h800100
  - layer 2: 0, 'h220000, 'h800200
  - wr_addr per layer: 'h100000, 0, 'h100000
  - one fc_done pulse at the end
- num_layers=0 → fc_done 2 cycles after fc_en; no rd_layer_start, rd_addr_en or wr_addr_en.
- rd_addr_rq and rd_end in the same cycle → wr_addr_en only, no rd_addr_en; rd_data_type=3'b011 → no pulse.
- rst_n low during WR of layer 1 → all outputs 0 immediately; a fresh fc_en restarts at layer 0 with rd_addr=DATA_BASE_A.
- With FC_SEQ_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16, wr_done withheld → fc_err=1 and fc_done after 16 idle WR cycles; the next start clears fc_err.
